// File: rtl/hier_relay_pkg.sv
// Shared types and constants for the hierarchical fanout relay.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
//
// Contents:
//   RELAY_DEPTH       number of storage entries (head + skid)
//   relay_count_t     occupancy type, holds 0..RELAY_DEPTH
//   relay_entry_t     default-width entry; modules re-declare it at their own WIDTH
//   relay_count_next  occupancy update for a push/pop pair
package hier_relay_pkg;

  localparam int RELAY_DEPTH         = 2;
  localparam int RELAY_WIDTH_DEFAULT = 8;

  typedef logic [1:0] relay_count_t;

  localparam relay_count_t RELAY_EMPTY = 2'd0;
  localparam relay_count_t RELAY_ONE   = 2'd1;
  localparam relay_count_t RELAY_FULL  = relay_count_t'(RELAY_DEPTH);

  // Reference entry layout. Parameterised modules declare an identical
  // struct sized by their own WIDTH parameter.
  typedef struct packed {
    logic [RELAY_WIDTH_DEFAULT-1:0] data;
  } relay_entry_t;

  // Occupancy after one cycle. Callers must only pass qualified push/pop:
  // no push when full, no pop when empty.
  function automatic relay_count_t relay_count_next(input relay_count_t cnt,
                                                    input logic         push,
                                                    input logic         pop);
    relay_count_t nxt;
    nxt = cnt;
    if (push && !pop) begin
      nxt = cnt + 2'd1;
    end else if (!push && pop) begin
      nxt = cnt - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/relay_entry_fifo.sv
// Two-entry head/skid word store for the fanout relay.
// Latency: a pushed word appears on head_data the cycle after the push, no bypass.
// Backpressure: push ignored when full, pop ignored when empty; push+pop when full is never honoured.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset (occupancy only)
//   push         write push_data this cycle
//   push_data    word to store
//   pop          discard the head word this cycle (skid moves up)
//   count        occupancy 0..2
//   head_valid   head entry holds a live word
//   head_data    head word; holds its last value when empty
module relay_entry_fifo
  import hier_relay_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output relay_count_t     count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
  } entry_t;

  relay_count_t count_q;
  entry_t       head_q;
  entry_t       skid_q;
  logic         push_ok;
  logic         pop_ok;

  // Qualify locally so a misbehaving caller cannot wrap the occupancy.
  assign push_ok = push && (count_q != RELAY_FULL);
  assign pop_ok  = pop  && (count_q != RELAY_EMPTY);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RELAY_EMPTY;
    end else begin
      count_q <= relay_count_next(count_q, push_ok, pop_ok);
    end
  end

  // Datapath flops carry no reset.
  // Head loads the incoming word when it becomes the oldest word:
  // either the store is empty, or the single head word leaves this cycle.
  // Otherwise a pop from full promotes the skid. A lone pop from a single
  // entry leaves head untouched so out_data keeps its last value.
  always_ff @(posedge clk) begin
    if (push_ok && ((count_q == RELAY_EMPTY) || (pop_ok && (count_q == RELAY_ONE)))) begin
      head_q.data <= push_data;
    end else if (pop_ok && (count_q == RELAY_FULL)) begin
      head_q <= skid_q;
    end

    if (push_ok && !pop_ok && (count_q == RELAY_ONE)) begin
      skid_q.data <= push_data;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != RELAY_EMPTY);
  assign head_data  = head_q.data;

endmodule

// File: rtl/hier_fanout_relay.sv
// Registered relay: one producer word buffered and broadcast to NUM_LOADS consumers.
// Latency: 1 cycle from accepted push to out_valid/out_data; a word retires once every load has taken it.
// Backpressure: in_ready drops when both entries are held (no push-on-pop when full) and while rst is high.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_ready/in_data     upstream handshake and word
//   out_valid[i]/out_ready[i]     per-load handshake; out_valid[i] clears once load i took the head
//   out_data        head word shared by all loads (not meaningful when no out_valid is set)
//   retired_count   words delivered to every load, wraps modulo 2^COUNT_W
module hier_fanout_relay
  import hier_relay_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_LOADS = 2,
  parameter int COUNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [NUM_LOADS-1:0] out_valid,
  input  logic [NUM_LOADS-1:0] out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [COUNT_W-1:0]   retired_count
);

  relay_count_t         count;
  logic                 head_valid;
  logic [WIDTH-1:0]     head_data;
  logic                 push;
  logic                 retire;
  logic [NUM_LOADS-1:0] taken_q;
  logic [NUM_LOADS-1:0] fire;
  logic [NUM_LOADS-1:0] done;
  logic [COUNT_W-1:0]   retired_count_q;

  // Ready comes from the occupancy flop; rst gates it so nothing is
  // accepted on a reset cycle. out_ready is deliberately not used here,
  // so a full store stays closed even in a cycle where the head retires.
  assign in_ready = !rst && (count != RELAY_FULL);
  assign push     = in_valid && in_ready;

  relay_entry_fifo #(
    .WIDTH (WIDTH)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (in_data),
    .pop        (retire),
    .count      (count),
    .head_valid (head_valid),
    .head_data  (head_data)
  );

  // out_valid depends only on flops, so in_valid never reaches it.
  assign out_valid = {NUM_LOADS{head_valid}} & ~taken_q;
  assign out_data  = head_data;

  // out_ready on a load whose out_valid is low is masked out by fire.
  assign fire   = out_valid & out_ready;
  assign done   = taken_q | fire;
  assign retire = head_valid && (&done);

  always_ff @(posedge clk) begin
    if (rst) begin
      taken_q         <= '0;
      retired_count_q <= '0;
    end else if (retire) begin
      taken_q         <= '0;
      retired_count_q <= retired_count_q + COUNT_W'(1);
    end else begin
      taken_q         <= done;
    end
  end

  assign retired_count = retired_count_q;

endmodule
